// File: rtl/uart_rx_frame_counter.sv
// Oversampling edge/bit counter for the UART receiver with a per-frame latched
// format (5-8 data bits, optional parity, 1/2 stop bits) and majority-vote strobes.
module uart_rx_frame_counter #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int MIN_PRESCALE   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [1:0]                data_bits,
    input  logic                      par_en,
    input  logic                      stop2,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      bit_done,
    output logic                      sample_strobe,
    output logic [1:0]                sample_idx,
    output logic                      frame_done,
    output logic                      active,
    output logic                      cfg_err
);

    localparam int W = PRESCALE_WIDTH;
    localparam logic [W-1:0] MIN_P = W'(MIN_PRESCALE);
    localparam logic [W-1:0] ONE_W = W'(1);

    logic [W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic         active_q, active_d;
    logic         cfg_err_q, cfg_err_d;
    logic [W-1:0] presc_q, presc_d;
    logic [1:0]   data_bits_q, data_bits_d;
    logic         par_en_q, par_en_d;
    logic         stop2_q, stop2_d;

    logic [W-1:0] eff_presc, pe, pe_m1, half, s_lo, s_hi;
    logic [1:0]   eff_data_bits;
    logic         eff_par_en, eff_stop2;
    logic [3:0]   frame_len, frame_last;
    logic         latch_en;

    // Until a frame is running the live inputs define the format, so the very
    // first enabled cycle is already timed with the configuration being latched.
    assign eff_presc     = active_q ? presc_q     : Prescale;
    assign eff_data_bits = active_q ? data_bits_q : data_bits;
    assign eff_par_en    = active_q ? par_en_q    : par_en;
    assign eff_stop2     = active_q ? stop2_q     : stop2;

    assign pe    = (eff_presc < MIN_P) ? MIN_P : eff_presc;
    assign pe_m1 = pe - ONE_W;
    assign half  = pe >> 1;
    assign s_lo  = half - ONE_W;
    assign s_hi  = half + ONE_W;

    assign frame_len  = 4'd6 + {2'b00, eff_data_bits} + {3'b000, eff_par_en}
                      + (eff_stop2 ? 4'd2 : 4'd1);
    assign frame_last = frame_len - 4'd1;

    assign bit_done   = enable & (edge_cnt_q == pe_m1);
    assign frame_done = bit_done & (bit_cnt_q == frame_last);
    assign latch_en   = enable & (~active_q | frame_done);

    always_comb begin
        sample_strobe = 1'b0;
        sample_idx    = 2'd0;
        if (enable) begin
            if (edge_cnt_q == s_lo) begin
                sample_strobe = 1'b1;
                sample_idx    = 2'd0;
            end else if (edge_cnt_q == half) begin
                sample_strobe = 1'b1;
                sample_idx    = 2'd1;
            end else if (edge_cnt_q == s_hi) begin
                sample_strobe = 1'b1;
                sample_idx    = 2'd2;
            end
        end
    end

    always_comb begin
        edge_cnt_d  = edge_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        active_d    = active_q;
        cfg_err_d   = cfg_err_q;
        presc_d     = presc_q;
        data_bits_d = data_bits_q;
        par_en_d    = par_en_q;
        stop2_d     = stop2_q;
        if (!enable) begin
            // Abort: drop the frame silently, shadow config is simply stale.
            edge_cnt_d = '0;
            bit_cnt_d  = 4'd0;
            active_d   = 1'b0;
            cfg_err_d  = 1'b0;
        end else begin
            if (latch_en) begin
                presc_d     = Prescale;
                data_bits_d = data_bits;
                par_en_d    = par_en;
                stop2_d     = stop2;
                active_d    = 1'b1;
                cfg_err_d   = cfg_err_q | (Prescale < MIN_P);
            end
            if (bit_done) begin
                edge_cnt_d = '0;
                bit_cnt_d  = frame_done ? 4'd0 : bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + ONE_W;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            active_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            presc_q     <= '0;
            data_bits_q <= 2'd0;
            par_en_q    <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            active_q    <= active_d;
            cfg_err_q   <= cfg_err_d;
            presc_q     <= presc_d;
            data_bits_q <= data_bits_d;
            par_en_q    <= par_en_d;
            stop2_q     <= stop2_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;
    assign active   = active_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Directed self-checking bench for uart_rx_frame_counter: reset, frame formats,
// mid-frame config changes, abort, prescale clamping and back-to-back frames.
module tb_uart_rx_frame_counter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [1:0] data_bits = 2'b11;
    logic       par_en = 1'b0;
    logic       stop2 = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       bit_done, sample_strobe, frame_done, active, cfg_err;
    logic [1:0] sample_idx;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    uart_rx_frame_counter #(.PRESCALE_WIDTH(6), .MIN_PRESCALE(4)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .Prescale(Prescale),
        .data_bits(data_bits), .par_en(par_en), .stop2(stop2),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_done(bit_done),
        .sample_strobe(sample_strobe), .sample_idx(sample_idx),
        .frame_done(frame_done), .active(active), .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check one enabled cycle; c counts enabled cycles from 1, frames of pe*f cycles.
    task automatic cyc(input int c, input int pe, input int h, input int f, input int exp_act);
        int n, e, b, bd, ss, si;
        n  = (c - 1) % (pe * f);
        e  = n % pe;
        b  = n / pe;
        bd = (e == pe - 1) ? 1 : 0;
        ss = (e >= h - 1 && e <= h + 1) ? 1 : 0;
        si = ss ? e - (h - 1) : 0;
        #1;
        check("edge_cnt", edge_cnt, e);
        check("bit_cnt", bit_cnt, b);
        check("bit_done", bit_done, bd);
        check("sample_strobe", sample_strobe, ss);
        check("sample_idx", sample_idx, si);
        check("frame_done", frame_done, (bd && b == f - 1) ? 1 : 0);
        check("active", active, exp_act);
        tick();
    endtask

    task automatic stop_and_idle();
        enable = 1'b0;
        #1;
        check("abort_bit_done", bit_done, 0);
        check("abort_frame_done", frame_done, 0);
        tick();
        check("idle_edge", edge_cnt, 0);
        check("idle_bit", bit_cnt, 0);
        check("idle_active", active, 0);
        check("idle_cfg_err", cfg_err, 0);
    endtask

    initial begin
        // 1: reset mid-count
        repeat (2) @(posedge CLK);
        #1;
        check("rst_edge", edge_cnt, 0);
        check("rst_active", active, 0);
        RST = 1'b1;
        Prescale = 6'd8; data_bits = 2'b11; par_en = 1'b0; stop2 = 1'b0;
        enable = 1'b1;
        for (int c = 1; c <= 20; c++) cyc(c, 8, 4, 10, c > 1);
        RST = 1'b0;
        #1;
        check("async_rst_edge", edge_cnt, 0);
        check("async_rst_bit", bit_cnt, 0);
        check("async_rst_bit_done", bit_done, 0);
        check("async_rst_strobe", sample_strobe, 0);
        check("async_rst_frame_done", frame_done, 0);
        check("async_rst_active", active, 0);
        check("async_rst_cfg_err", cfg_err, 0);
        RST = 1'b1;
        $display("TXN reset mid-count done checks=%0d failures=%0d", checks, failures);

        // 2: P=8 8N1, frame_done at cycle 80, cycle 81 starts next frame
        for (int c = 1; c <= 81; c++) cyc(c, 8, 4, 10, c > 1);
        stop_and_idle();
        $display("TXN P=8 8N1 frame done checks=%0d failures=%0d", checks, failures);

        // 3: P=16 5E2 (F=9); Prescale changed mid-frame applies to next frame
        Prescale = 6'd16; data_bits = 2'b00; par_en = 1'b1; stop2 = 1'b1;
        enable = 1'b1;
        for (int c = 1; c <= 144; c++) begin
            if (c == 50) Prescale = 6'd8;
            cyc(c, 16, 8, 9, c > 1);
        end
        for (int c = 1; c <= 72; c++) cyc(c, 8, 4, 9, 1);
        stop_and_idle();
        $display("TXN P=16 5E2 then P=8 checks=%0d failures=%0d", checks, failures);

        // 4: abort at bit_cnt=4 edge_cnt=5, then a full fresh frame
        Prescale = 6'd8; data_bits = 2'b11; par_en = 1'b0; stop2 = 1'b0;
        enable = 1'b1;
        for (int c = 1; c <= 37; c++) cyc(c, 8, 4, 10, c > 1);
        #1;
        check("pre_abort_edge", edge_cnt, 5);
        check("pre_abort_bit", bit_cnt, 4);
        stop_and_idle();
        enable = 1'b1;
        for (int c = 1; c <= 80; c++) cyc(c, 8, 4, 10, c > 1);
        stop_and_idle();
        $display("TXN abort and re-enable checks=%0d failures=%0d", checks, failures);

        // 5: Prescale=2 is clamped to 4 and flags cfg_err
        Prescale = 6'd2;
        enable = 1'b1;
        #1;
        check("cfg_err_before_latch", cfg_err, 0);
        cyc(1, 4, 2, 10, 0);
        check("cfg_err_latched", cfg_err, 1);
        for (int c = 2; c <= 40; c++) cyc(c, 4, 2, 10, 1);
        check("cfg_err_sticky", cfg_err, 1);
        stop_and_idle();
        $display("TXN prescale clamp checks=%0d failures=%0d", checks, failures);

        // 6: P=5 7O1 (F=10, H=2), two back-to-back frames
        Prescale = 6'd5; data_bits = 2'b10; par_en = 1'b1; stop2 = 1'b0;
        enable = 1'b1;
        for (int c = 1; c <= 100; c++) cyc(c, 5, 2, 10, c > 1);
        stop_and_idle();
        $display("TXN P=5 7O1 back-to-back checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
